// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths, opcodes, load funct3 codes and exception bit positions
package wb_stage_pkg;
    localparam int XLEN          = 32;
    localparam int REG_IDX_WIDTH = 5;
    localparam int INSTR_WIDTH   = 32;
    localparam int EXCP_WIDTH    = 5;

    localparam logic [6:0] INSTR_LD = 7'b0000011;
    localparam logic [6:0] INSTR_ST = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int EXCP_LD_MISALIGN     = 4;
    localparam int EXCP_LD_BUS_ERR      = 3;
    localparam int EXCP_ST_AMO_MISALIGN = 2;
    localparam int EXCP_ST_AMO_BUS_ERR  = 1;
    localparam int EXCP_BAD_ADDR        = 0;
endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-stage input handshake and register-file write port of the writeback stage
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic                     mem_valid_i;
    logic                     mem_ready_o;
    logic [INSTR_WIDTH-1:0]   mem_instr_i;
    logic [REG_IDX_WIDTH-1:0] mem_rd_idx_i;
    logic                     mem_rd_en_i;
    logic [XLEN-1:0]          mem_rd_wdata_i;
    logic [XLEN-1:0]          mem_addr_i;
    logic [EXCP_WIDTH-1:0]    mem_excp_i;
    logic                     wb_stall_i;
    logic                     wb_flush_i;
    logic                     wb_valid_o;
    logic                     wb_rd_en_o;
    logic [REG_IDX_WIDTH-1:0] wb_rd_idx_o;
    logic [XLEN-1:0]          wb_rd_wdata_o;
    logic [EXCP_WIDTH-1:0]    wb_excp_o;
    logic                     wb_illegal_o;
    logic [63:0]              wb_instret_o;

    modport slave (
        input  mem_valid_i, mem_instr_i, mem_rd_idx_i, mem_rd_en_i, mem_rd_wdata_i,
               mem_addr_i, mem_excp_i, wb_stall_i, wb_flush_i,
        output mem_ready_o, wb_valid_o, wb_rd_en_o, wb_rd_idx_o, wb_rd_wdata_o,
               wb_excp_o, wb_illegal_o, wb_instret_o
    );

    modport master (
        output mem_valid_i, mem_instr_i, mem_rd_idx_i, mem_rd_en_i, mem_rd_wdata_i,
               mem_addr_i, mem_excp_i, wb_stall_i, wb_flush_i,
        input  mem_ready_o, wb_valid_o, wb_rd_en_o, wb_rd_idx_o, wb_rd_wdata_o,
               wb_excp_o, wb_illegal_o, wb_instret_o
    );
endinterface

// File: rtl/wb_stage_load_ext.sv
// rtl/wb_stage_load_ext.sv - combinational load lane select with sign/zero extension
module wb_stage_load_ext
    import wb_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            illegal
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // offset[0] is ignored for halfwords; misalignment is trapped upstream
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data    = word;
        illegal = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'd0, byte_sel};
            F3_LH:  data = {{16{half_sel[15]}}, half_sel};
            F3_LHU: data = {16'd0, half_sel};
            F3_LW:  data = word;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback pipeline register, register-file write gating and retired-instruction counter
module wb_stage
    import wb_stage_pkg::*;
(
    input logic        clk,
    input logic        rst,
    wb_stage_if.slave  bus
);
    logic                     accept;
    logic                     valid_q;
    logic                     rd_en_q;
    logic [REG_IDX_WIDTH-1:0] rd_idx_q;
    logic                     is_load_q;
    logic [2:0]               funct3_q;
    logic [1:0]               offset_q;
    logic [XLEN-1:0]          wdata_q;
    logic [EXCP_WIDTH-1:0]    excp_q;
    logic [63:0]              instret_q;

    logic [XLEN-1:0]          ext_data;
    logic                     ext_illegal;
    logic                     illegal;
    logic                     retire;
    logic                     unused_bits;

    assign unused_bits = ^{bus.mem_instr_i[31:15], bus.mem_instr_i[11:7], bus.mem_addr_i[XLEN-1:2]};

    assign bus.mem_ready_o = ~bus.wb_stall_i;
    assign accept = bus.mem_valid_i & bus.mem_ready_o & ~bus.wb_flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_idx_q  <= '0;
            is_load_q <= 1'b0;
            funct3_q  <= 3'd0;
            offset_q  <= 2'd0;
            wdata_q   <= '0;
            excp_q    <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                rd_en_q   <= bus.mem_rd_en_i;
                rd_idx_q  <= bus.mem_rd_idx_i;
                is_load_q <= (bus.mem_instr_i[6:0] == INSTR_LD);
                funct3_q  <= bus.mem_instr_i[14:12];
                offset_q  <= bus.mem_addr_i[1:0];
                wdata_q   <= bus.mem_rd_wdata_i;
                excp_q    <= bus.mem_excp_i;
            end
        end
    end

    wb_stage_load_ext u_load_ext (
        .funct3  (funct3_q),
        .offset  (offset_q),
        .word    (wdata_q),
        .data    (ext_data),
        .illegal (ext_illegal)
    );

    assign illegal = valid_q & is_load_q & ext_illegal;
    assign retire  = valid_q & ~|excp_q & ~illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    // An instruction sitting in the register while rst is high is discarded, so its write is suppressed
    assign bus.wb_valid_o    = valid_q;
    assign bus.wb_rd_en_o    = retire & rd_en_q & (rd_idx_q != '0) & ~rst;
    assign bus.wb_rd_idx_o   = rd_idx_q;
    assign bus.wb_rd_wdata_o = is_load_q ? ext_data : wdata_q;
    assign bus.wb_excp_o     = valid_q ? excp_q : '0;
    assign bus.wb_illegal_o  = illegal;
    assign bus.wb_instret_o  = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - table-driven and sequence checks for wb_stage
module tb_wb_stage;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rd_en;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [4:0]  excp;
        logic        e_en;
        logic [31:0] e_wdata;
        logic        e_ill;
        logic        e_ret;
    } vec_t;

    localparam int NV = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   writes;
    logic [63:0] model_instret;
    vec_t vecs [NV];

    wb_stage_if bus ();

    wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rd_en, input logic [31:0] wdata, input logic [31:0] addr,
                         input logic [4:0] excp);
        bus.mem_valid_i    = 1'b1;
        bus.mem_instr_i    = {17'd0, f3, 5'd0, op};
        bus.mem_rd_idx_i   = rd;
        bus.mem_rd_en_i    = rd_en;
        bus.mem_rd_wdata_i = wdata;
        bus.mem_addr_i     = addr;
        bus.mem_excp_i     = excp;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_instret = 64'd0;

        //          op      f3      rd    en    wdata          addr        excp      e_en  e_wdata        ill   ret
        vecs[0]  = '{OP_LD,  3'b000, 5'd1, 1'b1, 32'h80123456, 32'h103, 5'b00000, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1};
        vecs[1]  = '{OP_LD,  3'b100, 5'd1, 1'b1, 32'h80123456, 32'h103, 5'b00000, 1'b1, 32'h00000080, 1'b0, 1'b1};
        vecs[2]  = '{OP_LD,  3'b101, 5'd2, 1'b1, 32'hBEEF1234, 32'h102, 5'b00000, 1'b1, 32'h0000BEEF, 1'b0, 1'b1};
        vecs[3]  = '{OP_LD,  3'b001, 5'd2, 1'b1, 32'hBEEF1234, 32'h102, 5'b00000, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b1};
        vecs[4]  = '{OP_LD,  3'b010, 5'd2, 1'b1, 32'hBEEF1234, 32'h102, 5'b00000, 1'b1, 32'hBEEF1234, 1'b0, 1'b1};
        vecs[5]  = '{OP_LD,  3'b000, 5'd3, 1'b1, 32'hBEEF1234, 32'h101, 5'b00000, 1'b1, 32'h00000012, 1'b0, 1'b1};
        vecs[6]  = '{OP_LD,  3'b001, 5'd3, 1'b1, 32'h12348001, 32'h100, 5'b00000, 1'b1, 32'hFFFF8001, 1'b0, 1'b1};
        vecs[7]  = '{OP_LD,  3'b101, 5'd3, 1'b1, 32'h80010000, 32'h103, 5'b00000, 1'b1, 32'h00008001, 1'b0, 1'b1};
        vecs[8]  = '{OP_LD,  3'b000, 5'd3, 1'b1, 32'h00FE0000, 32'h102, 5'b00000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1};
        vecs[9]  = '{OP_ALU, 3'b000, 5'd0, 1'b1, 32'h00000005, 32'h000, 5'b00000, 1'b0, 32'h00000005, 1'b0, 1'b1};
        vecs[10] = '{OP_ALU, 3'b000, 5'd7, 1'b1, 32'h00000005, 32'h000, 5'b00000, 1'b1, 32'h00000005, 1'b0, 1'b1};
        vecs[11] = '{OP_LD,  3'b010, 5'd8, 1'b1, 32'h00000011, 32'h001, 5'b10000, 1'b0, 32'h00000011, 1'b0, 1'b0};
        vecs[12] = '{OP_LD,  3'b011, 5'd8, 1'b1, 32'h00000022, 32'h000, 5'b00000, 1'b0, 32'h00000022, 1'b1, 1'b0};
        vecs[13] = '{OP_ALU, 3'b000, 5'd5, 1'b0, 32'h00000033, 32'h000, 5'b00000, 1'b0, 32'h00000033, 1'b0, 1'b1};
        vecs[14] = '{OP_ST,  3'b010, 5'd6, 1'b0, 32'h00000044, 32'h004, 5'b00000, 1'b0, 32'h00000044, 1'b0, 1'b1};
        vecs[15] = '{OP_ALU, 3'b011, 5'd6, 1'b1, 32'hCAFE0001, 32'h003, 5'b00000, 1'b1, 32'hCAFE0001, 1'b0, 1'b1};

        rst = 1'b1;
        bus.mem_valid_i = 1'b0;
        bus.wb_stall_i  = 1'b0;
        bus.wb_flush_i  = 1'b0;
        drive(OP_ALU, 3'b000, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        bus.mem_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, bus.wb_valid_o}, 64'd0);
        chk("rst_rd_en", {63'd0, bus.wb_rd_en_o}, 64'd0);
        chk("rst_rd_idx", {59'd0, bus.wb_rd_idx_o}, 64'd0);
        chk("rst_wdata", {32'd0, bus.wb_rd_wdata_o}, 64'd0);
        chk("rst_excp", {59'd0, bus.wb_excp_o}, 64'd0);
        chk("rst_illegal", {63'd0, bus.wb_illegal_o}, 64'd0);
        chk("rst_instret", bus.wb_instret_o, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].rd_en, vecs[i].wdata, vecs[i].addr, vecs[i].excp);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {63'd0, bus.wb_valid_o}, 64'd1);
            chk($sformatf("v%0d_rd_en", i), {63'd0, bus.wb_rd_en_o}, {63'd0, vecs[i].e_en});
            chk($sformatf("v%0d_rd_idx", i), {59'd0, bus.wb_rd_idx_o}, {59'd0, vecs[i].rd});
            chk($sformatf("v%0d_wdata", i), {32'd0, bus.wb_rd_wdata_o}, {32'd0, vecs[i].e_wdata});
            chk($sformatf("v%0d_illegal", i), {63'd0, bus.wb_illegal_o}, {63'd0, vecs[i].e_ill});
            chk($sformatf("v%0d_excp", i), {59'd0, bus.wb_excp_o}, {59'd0, vecs[i].excp});
            chk($sformatf("v%0d_instret", i), bus.wb_instret_o, model_instret);
            if (vecs[i].e_ret) model_instret = model_instret + 64'd1;
        end
        bus.mem_valid_i = 1'b0;
        @(negedge clk);
        chk("table_instret", bus.wb_instret_o, model_instret);
        chk("idle_valid", {63'd0, bus.wb_valid_o}, 64'd0);

        // exception is presented for exactly one cycle
        drive(OP_LD, 3'b010, 5'd9, 1'b1, 32'h1, 32'h0, 5'b10000);
        @(negedge clk);
        chk("excp_once", {59'd0, bus.wb_excp_o}, 64'h10);
        bus.mem_valid_i = 1'b0;
        @(negedge clk);
        chk("excp_cleared", {59'd0, bus.wb_excp_o}, 64'd0);
        chk("excp_instret", bus.wb_instret_o, model_instret);

        // stall for three cycles, then a single accept and a single write
        writes = 0;
        drive(OP_ALU, 3'b000, 5'd9, 1'b1, 32'h99, 32'h0, 5'd0);
        bus.wb_stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_ready", c), {63'd0, bus.mem_ready_o}, 64'd0);
            @(negedge clk);
            chk($sformatf("stall%0d_bubble", c), {63'd0, bus.wb_valid_o}, 64'd0);
            writes += int'(bus.wb_rd_en_o);
        end
        bus.wb_stall_i = 1'b0;
        #1;
        chk("release_ready", {63'd0, bus.mem_ready_o}, 64'd1);
        @(negedge clk);
        chk("release_valid", {63'd0, bus.wb_valid_o}, 64'd1);
        chk("release_wdata", {32'd0, bus.wb_rd_wdata_o}, 64'h99);
        writes += int'(bus.wb_rd_en_o);
        bus.mem_valid_i = 1'b0;
        model_instret = model_instret + 64'd1;
        @(negedge clk);
        writes += int'(bus.wb_rd_en_o);
        chk("stall_write_count", 64'(writes), 64'd1);
        chk("stall_instret", bus.wb_instret_o, model_instret);

        // flush kills the instruction being accepted
        drive(OP_ALU, 3'b000, 5'd10, 1'b1, 32'hA, 32'h0, 5'd0);
        bus.wb_flush_i = 1'b1;
        @(negedge clk);
        chk("flush_valid", {63'd0, bus.wb_valid_o}, 64'd0);
        chk("flush_rd_en", {63'd0, bus.wb_rd_en_o}, 64'd0);
        bus.wb_flush_i = 1'b0;

        // flush with stall: bubble, but the held instruction still completes
        drive(OP_ALU, 3'b000, 5'd11, 1'b1, 32'hB, 32'h0, 5'd0);
        @(negedge clk);
        drive(OP_ALU, 3'b000, 5'd12, 1'b1, 32'hC, 32'h0, 5'd0);
        bus.wb_flush_i = 1'b1;
        bus.wb_stall_i = 1'b1;
        #1;
        chk("fs_old_rd_en", {63'd0, bus.wb_rd_en_o}, 64'd1);
        chk("fs_old_idx", {59'd0, bus.wb_rd_idx_o}, 64'd11);
        model_instret = model_instret + 64'd1;
        @(negedge clk);
        chk("fs_bubble", {63'd0, bus.wb_valid_o}, 64'd0);
        chk("fs_instret", bus.wb_instret_o, model_instret);
        bus.wb_flush_i  = 1'b0;
        bus.wb_stall_i  = 1'b0;
        bus.mem_valid_i = 1'b0;

        // instret wraps from all ones to zero on a retire
        drive(OP_ALU, 3'b000, 5'd4, 1'b1, 32'h1, 32'h0, 5'd0);
        @(negedge clk);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap_preset", bus.wb_instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.mem_valid_i = 1'b0;
        @(negedge clk);
        chk("wrap_zero", bus.wb_instret_o, 64'd0);

        // reset with a retiring instruction held: no write, counter cleared
        drive(OP_ALU, 3'b000, 5'd4, 1'b1, 32'h2, 32'h0, 5'd0);
        @(negedge clk);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        bus.mem_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_hold_no_write", {63'd0, bus.wb_rd_en_o}, 64'd0);
        @(negedge clk);
        chk("rst_hold_instret", bus.wb_instret_o, 64'd0);
        chk("rst_hold_valid", {63'd0, bus.wb_valid_o}, 64'd0);
        chk("rst_hold_rd_en", {63'd0, bus.wb_rd_en_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage placed directly downstream of the memory-access stage. It registers the memory stage's result behind a valid/ready handshake and performs load byte and halfword lane selection with sign or zero extension on the raw 32-bit memory word. It then drives the register-file write port and exposes the write as a forwarding source. It also gates writes on exceptions and keeps the 64-bit retired-instruction counter.

## Interface
- XLEN, 32, data and address width
- REG_IDX_WIDTH, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  memory stage presents an instruction this cycle
- mem_ready_o  out  1  stage accepts this cycle; equals ~wb_stall_i
- mem_instr_i  in  32  instruction word (opcode [6:0], funct3 [14:12])
- mem_rd_idx_i  in  REG_IDX_WIDTH  destination register
- mem_rd_en_i  in  1  instruction writes rd
- mem_rd_wdata_i  in  XLEN  for loads, the raw aligned memory word; otherwise the ALU result
- mem_addr_i  in  XLEN  access address (only [1:0] used)
- mem_excp_i  in  5  {ld_misalign, ld_bus_err, st_amo_misalign, st_amo_bus_err, bad_addr}
- wb_stall_i  in  1  hazard unit holds upstream
- wb_flush_i  in  1  kill the instruction being accepted this cycle
- wb_valid_o  out  1  registered instruction present
- wb_rd_en_o  out  1  register-file write enable
- wb_rd_idx_o  out  REG_IDX_WIDTH  write index
- wb_rd_wdata_o  out  XLEN  write data, already extended
- wb_excp_o  out  5  registered exception bits, qualified by valid
- wb_illegal_o  out  1  load with reserved funct3
- wb_instret_o  out  64  retired-instruction count

## Operation
- Accept condition: mem_valid_i & mem_ready_o & ~wb_flush_i.
  - On accept, capture rd_idx, rd_en, the load flag (opcode == INSTR_LD), funct3, addr[1:0], wdata and excp.
  - Set valid_q = 1.
- If the accept condition is false, valid_q = 0 next cycle. Every accepted instruction is presented for exactly one cycle; a stall inserts a bubble.
- Load extension, applied only when the load flag is set (word W, offset a = addr[1:0]):
  - funct3 000 lb: byte W[8a+7:8a], sign-extended.
  - funct3 100 lbu: same byte, zero-extended.
  - funct3 001 lh: halfword W[16a1+15:16a1] with a1 = a[1], sign-extended. a[0] is ignored; misalignment is flagged upstream.
  - funct3 101 lhu: same halfword, zero-extended.
  - funct3 010 lw: W unchanged.
  - funct3 011, 110, 111: wb_illegal_o = 1, no write.
- Non-load instructions: wdata passes through unchanged.
- Write enable: wb_rd_en_o = valid_q & rd_en_q & (rd_idx_q != 0) & ~|excp_q & ~illegal. x0 is never written.
- wb_excp_o = valid_q ? excp_q : 0. wb_illegal_o is likewise qualified by valid_q.
- Retire condition: valid_q & ~|excp_q & ~illegal. A write to x0 still retires.
- instret increments by 1 on each retire cycle and wraps modulo 2^64.

## Timing
- Latency is 1 cycle from the accepting edge to the register-file write.
- Outputs are registered state plus the extension logic; mem_ready_o is the only combinational path (from wb_stall_i).
- Reset is synchronous and takes effect on the rising edge with rst = 1. Reset values:
  - valid_q, and therefore wb_valid_o, wb_rd_en_o, wb_excp_o and wb_illegal_o: 0.
  - wb_rd_idx_o: 0.
  - wb_rd_wdata_o: 0.
  - wb_instret_o: 0.
- Reset overrides accept, flush and increment. rst asserted while an instruction is in the register: that instruction neither writes nor retires.
- Priority: rst > wb_flush_i > wb_stall_i > accept.
- wb_flush_i and wb_stall_i together: bubble. The instruction already in the register still completes that cycle.
- Data fields of the register may hold stale values while valid_q = 0; only valid-qualified outputs are meaningful.
- Forwarding: consumers use wb_rd_en_o, wb_rd_idx_o and wb_rd_wdata_o in the same cycle.

## Structure
- defines.v: XLEN, REG_IDX_WIDTH, INSTR_WIDTH, INSTR_LD, INSTR_ST, load funct3 codes (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), exception bit positions.
- Sub-module load_ext: combinational; inputs funct3, offset and word; outputs the extended data and an illegal flag.
- wb_stage holds the pipeline register, write gating and instret counter.

## Test plan
- lb with funct3 000, addr 0x103, word 0x80_12_34_56 -> next cycle wb_rd_wdata_o = 0xFFFFFF80, wb_rd_en_o = 1, instret 0 -> 1.
- lhu with addr 0x102, word 0xBEEF_1234 -> 0x0000BEEF. lh with the same inputs -> 0xFFFFBEEF. lw -> 0xBEEF1234.
- ALU op with rd = x0 and wdata 5 -> wb_rd_en_o = 0, instret still increments. Same op with rd = x7 -> write 5 to x7.
- Load with mem_excp_i = 5'b10000 -> wb_excp_o = 5'b10000 for one cycle, no write, instret unchanged. Load with funct3 011 -> wb_illegal_o = 1, no write.
- wb_stall_i high for 3 cycles with mem_valid_i = 1 -> mem_ready_o = 0 and a bubble each cycle. On release, the instruction is accepted once and written once.
- wb_flush_i with a valid input -> no write next cycle. rst asserted with instret = 0xFFFF_FFFF_FFFF_FFFF and a retiring instruction in the register -> instret = 0 and no write. Without rst, the same retire wraps instret to 0.
